// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between instruction fetch and data load.
// Optional RD_ERR_STICKY_EN adds a sticky read-error flag (rd_err) and the grant that first hit it (rd_err_id).
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_len,
  output logic                  i_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  output logic                  i_rsp_last,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [7:0]            d_req_len,
  input  logic [2:0]            d_req_size,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_last,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef RD_ERR_STICKY_EN
  ,
  output logic                  rd_err,
  output logic                  rd_err_id
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic       GNT_I = 1'b0;
  localparam logic       GNT_D = 1'b1;

  logic [1:0] state;
  logic       grant, last_grant;
  logic       win_d, take, r_fire;

  // Load wins when alone or when fetch had the previous burst.
  assign win_d  = d_req_valid & (~i_req_valid | (last_grant == GNT_I));
  assign take   = (state == IDLE) & reset & (i_req_valid | d_req_valid);
  assign r_fire = (state == DATA) & m_axi_rvalid & m_axi_rready;

  assign i_req_ready = take & ~win_d;
  assign d_req_ready = take & win_d;

  assign m_axi_rready = (state == DATA) & ((grant == GNT_D) ? d_rsp_ready : i_rsp_ready);
  assign i_rsp_valid  = (state == DATA) & (grant == GNT_I) & m_axi_rvalid;
  assign d_rsp_valid  = (state == DATA) & (grant == GNT_D) & m_axi_rvalid;
  assign i_rsp_data   = m_axi_rdata;
  assign d_rsp_data   = m_axi_rdata;
  assign i_rsp_last   = m_axi_rlast;
  assign d_rsp_last   = m_axi_rlast;
  assign m_axi_arlock = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= GNT_I;
      last_grant    <= GNT_D;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arcache <= '0;
      m_axi_arprot  <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          grant         <= win_d;
          m_axi_arid    <= {{(ID_WIDTH-1){1'b0}}, win_d};
          m_axi_araddr  <= win_d ? d_req_addr : i_req_addr;
          m_axi_arlen   <= win_d ? d_req_len : i_req_len;
          m_axi_arsize  <= win_d ? d_req_size : 3'b011;
          m_axi_arburst <= win_d ? 2'b01 : 2'b10;
          m_axi_arcache <= 4'b0011;
          m_axi_arprot  <= win_d ? 3'b000 : 3'b100;
          m_axi_arvalid <= 1'b1;
          state         <= ADDR;
        end
        ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          state         <= DATA;
        end
        DATA: if (r_fire && m_axi_rlast) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single outstanding burst, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

`ifdef RD_ERR_STICKY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_err    <= 1'b0;
      rd_err_id <= 1'b0;
    end else if (r_fire && (m_axi_rresp != 2'b00) && !rd_err) begin
      rd_err    <= 1'b1;
      rd_err_id <= grant;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: drives requesters and a hand-played AXI slave.
module tb_axi_rd_arbiter;
  localparam int IW = 13, AW = 64, DW = 64;

  logic clk, reset;
  logic i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_last;
  logic [AW-1:0] i_req_addr, d_req_addr, m_axi_araddr;
  logic [7:0] i_req_len, d_req_len, m_axi_arlen;
  logic [DW-1:0] i_rsp_data, d_rsp_data, m_axi_rdata;
  logic d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_last;
  logic [2:0] d_req_size, m_axi_arsize, m_axi_arprot;
  logic [IW-1:0] m_axi_arid, m_axi_rid;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic m_axi_arlock, m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [3:0] m_axi_arcache;
`ifdef RD_ERR_STICKY_EN
  logic rd_err, rd_err_id;
`endif

  int vectors = 0, miscompares = 0;
  logic [127:0] got, exp;

  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_last(i_rsp_last),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_len(d_req_len),
    .d_req_size(d_req_size), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_last(d_rsp_last),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef RD_ERR_STICKY_EN
    , .rd_err(rd_err), .rd_err_id(rd_err_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] ar_bundle();
    return {29'd0, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid};
  endfunction

  function automatic logic [127:0] ar_exp(logic [IW-1:0] id, logic [AW-1:0] a, logic [7:0] l,
                                          logic [2:0] sz, logic [1:0] b, logic [2:0] p);
    return {29'd0, id, a, l, sz, b, 1'b0, 4'b0011, p, 1'b1};
  endfunction

  task automatic test_reset;
    reset = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    step; step;
    got = ar_bundle() | {123'd0, m_axi_rready, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid};
    exp = '0;
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    i_req_valid = 1'b0; d_req_valid = 1'b0; i_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
    reset = 1'b1; step;
  endtask

  task automatic test_tie;
    i_req_valid = 1'b1; i_req_addr = 64'h1000; i_req_len = 8'd0;
    d_req_valid = 1'b1; d_req_addr = 64'h3000; d_req_len = 8'd0; d_req_size = 3'b011;
    #1;
    vectors++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL tie_first_fetch: got %b want 10", {i_req_ready, d_req_ready});
    end
    step;
    vectors++;
    if ({i_req_ready, d_req_ready, m_axi_arvalid, m_axi_arid} !== {3'b001, 13'd0}) begin
      miscompares++; $display("FAIL tie_holdoff: got %h want %h", {i_req_ready, d_req_ready, m_axi_arvalid, m_axi_arid}, {3'b001, 13'd0});
    end
    m_axi_arready = 1'b1; step;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'hAA; i_rsp_ready = 1'b1; #1;
    vectors++;
    if ({i_rsp_valid, i_rsp_last, d_rsp_valid, i_req_ready, d_req_ready, m_axi_rready} !== 6'b110001) begin
      miscompares++; $display("FAIL tie_fetch_beat: got %b want 110001", {i_rsp_valid, i_rsp_last, d_rsp_valid, i_req_ready, d_req_ready, m_axi_rready});
    end
    step;
    m_axi_rvalid = 1'b0; #1;
    vectors++;
    if ({i_req_ready, d_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL tie_second_load: got %b want 01", {i_req_ready, d_req_ready});
    end
    step;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    vectors++;
    if ({m_axi_arvalid, m_axi_arid, m_axi_araddr} !== {1'b1, 13'd1, 64'h3000}) begin
      miscompares++; $display("FAIL tie_load_ar: got %h want %h", {m_axi_arvalid, m_axi_arid, m_axi_araddr}, {1'b1, 13'd1, 64'h3000});
    end
    step;
    m_axi_rvalid = 1'b1; d_rsp_ready = 1'b1; #1;
    vectors++;
    if ({d_rsp_valid, d_rsp_last, i_rsp_valid} !== 3'b110) begin
      miscompares++; $display("FAIL tie_load_beat: got %b want 110", {d_rsp_valid, d_rsp_last, i_rsp_valid});
    end
    step;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; d_rsp_ready = 1'b0;
  endtask

  task automatic test_fetch_only;
    i_req_valid = 1'b1; i_req_addr = 64'h1000; i_req_len = 8'd7; #1;
    vectors++;
    if (i_req_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_accept: got %b want 1", i_req_ready); end
    step;
    i_req_valid = 1'b0;
    got = ar_bundle(); exp = ar_exp(13'd0, 64'h1000, 8'd7, 3'b011, 2'b10, 3'b100);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fetch_ar: got %h want %h", got, exp); end
    m_axi_arready = 1'b1; step;
    vectors++;
    if (m_axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL fetch_ar_drop: got %b want 0", m_axi_arvalid); end
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = 64'h100 + 64'(k); m_axi_rlast = (k == 7); #1;
      got = {59'd0, i_rsp_valid, i_rsp_data, i_rsp_last, m_axi_rready, d_rsp_valid, 2'b00};
      exp = {59'd0, 1'b1, 64'h100 + 64'(k), (k == 7), 1'b1, 1'b0, 2'b00};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL fetch_beat%0d: got %h want %h", k, got, exp); end
      step;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; i_req_valid = 1'b1; #1;
    vectors++;
    if ({i_rsp_valid, m_axi_rready, i_req_ready} !== 3'b001) begin
      miscompares++; $display("FAIL fetch_idle_after: got %b want 001", {i_rsp_valid, m_axi_rready, i_req_ready});
    end
    i_req_valid = 1'b0; i_rsp_ready = 1'b0; #1;
  endtask

  task automatic test_load_only;
    d_req_valid = 1'b1; d_req_addr = 64'h2008; d_req_len = 8'd0; d_req_size = 3'b010; #1;
    vectors++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL load_accept: got %b want 10", {d_req_ready, i_req_ready});
    end
    step;
    d_req_valid = 1'b0;
    got = ar_bundle(); exp = ar_exp(13'd1, 64'h2008, 8'd0, 3'b010, 2'b01, 3'b000);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_ar: got %h want %h", got, exp); end
    step;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'hDEAD_BEEF; m_axi_rresp = 2'b10; d_rsp_ready = 1'b1; #1;
    got = {61'd0, d_rsp_valid, d_rsp_last, d_rsp_data, i_rsp_valid, m_axi_rready};
    exp = {61'd0, 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_beat: got %h want %h", got, exp); end
    step;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; #1;
    vectors++;
    if ({d_rsp_valid, m_axi_rready} !== 2'b00) begin
      miscompares++; $display("FAIL load_idle_after: got %b want 00", {d_rsp_valid, m_axi_rready});
    end
`ifdef RD_ERR_STICKY_EN
    vectors++;
    if ({rd_err, rd_err_id} !== 2'b11) begin
      miscompares++; $display("FAIL rd_err_sticky: got %b want 11", {rd_err, rd_err_id});
    end
`endif
    d_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    i_req_valid = 1'b1; i_req_addr = 64'h4000; i_req_len = 8'd3;
    step; i_req_valid = 1'b0; step;
    i_rsp_ready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 64'h50; step;
    m_axi_rdata = 64'h51; i_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      got = {62'd0, m_axi_rready, i_rsp_valid, i_rsp_data};
      exp = {62'd0, 1'b0, 1'b1, 64'h51};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL bp_stall%0d: got %h want %h", c, got, exp); end
      step;
    end
    i_rsp_ready = 1'b1; #1;
    vectors++;
    if ({m_axi_rready, i_rsp_data} !== {1'b1, 64'h51}) begin
      miscompares++; $display("FAIL bp_resume: got %h want %h", {m_axi_rready, i_rsp_data}, {1'b1, 64'h51});
    end
    step;
    m_axi_rdata = 64'h52; step;
    m_axi_rdata = 64'h53; m_axi_rlast = 1'b1; #1;
    vectors++;
    if ({i_rsp_valid, i_rsp_last, m_axi_rready} !== 3'b111) begin
      miscompares++; $display("FAIL bp_last: got %b want 111", {i_rsp_valid, i_rsp_last, m_axi_rready});
    end
    step;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; #1;
    vectors++;
    if (m_axi_rready !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after: got %b want 0", m_axi_rready); end
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_arready_delay;
    m_axi_arready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 64'h6000; d_req_len = 8'd1; d_req_size = 3'b011;
    step; d_req_valid = 1'b0; d_rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      got = ar_bundle(); exp = ar_exp(13'd1, 64'h6000, 8'd1, 3'b011, 2'b01, 3'b000);
      vectors++;
      if (got !== exp || m_axi_rready !== 1'b0) begin
        miscompares++; $display("FAIL arwait%0d: got %h rready %b want %h rready 0", c, got, m_axi_rready, exp);
      end
      step;
    end
    m_axi_arready = 1'b1; step;
    vectors++;
    if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin
      miscompares++; $display("FAIL arwait_data: got %b want 01", {m_axi_arvalid, m_axi_rready});
    end
    m_axi_rvalid = 1'b1; step;
    m_axi_rlast = 1'b1; step;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; d_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    i_req_valid = 1'b1; i_req_addr = 64'h8000; i_req_len = 8'd7;
    step; i_req_valid = 1'b0; step;
    i_rsp_ready = 1'b1; m_axi_rvalid = 1'b1;
    m_axi_rdata = 64'h80; step;
    m_axi_rdata = 64'h81; step;
    m_axi_rdata = 64'h82; reset = 1'b0; step;
    got = ar_bundle() | {123'd0, m_axi_rready, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid};
    exp = '0;
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL midreset_outputs: got %h want %h", got, exp); end
    m_axi_rvalid = 1'b0; reset = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 64'h9000; i_req_len = 8'd0; #1;
    vectors++;
    if (i_req_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_regrant: got %b want 1", i_req_ready); end
    step; i_req_valid = 1'b0;
    got = ar_bundle(); exp = ar_exp(13'd0, 64'h9000, 8'd0, 3'b011, 2'b10, 3'b100);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL midreset_ar: got %h want %h", got, exp); end
    step;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'h90; #1;
    vectors++;
    if ({i_rsp_valid, i_rsp_last, i_rsp_data} !== {2'b11, 64'h90}) begin
      miscompares++; $display("FAIL midreset_beat: got %h want %h", {i_rsp_valid, i_rsp_last, i_rsp_data}, {2'b11, 64'h90});
    end
    step;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; i_rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_len = '0; i_rsp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_len = '0; d_req_size = '0; d_rsp_ready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    test_reset;
    test_tie;
    test_fetch_only;
    test_load_only;
    test_backpressure;
    test_arready_delay;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
